// File: rtl/axi_write_vector_pkg.sv
// Width helpers for axi_write_vector and its beat extractor.
package axi_write_vector_pkg;

  // Width needed to hold a vector length in 0..max_len.
  function automatic int unsigned len_w(input int unsigned max_len);
    return (max_len <= 1) ? 1 : $clog2(max_len + 1);
  endfunction

  // Most beats a vector of max_len bits can need on a w-bit stream (at least one).
  function automatic int unsigned max_beats(input int unsigned max_len, input int unsigned w);
    int unsigned nb;
    nb = (max_len + w - 1) / w;
    return (nb < 1) ? 1 : nb;
  endfunction

  // Width of a beat counter that can also hold the beat count itself.
  function automatic int unsigned beat_w(input int unsigned max_len, input int unsigned w);
    return $clog2(max_beats(max_len, w) + 1);
  endfunction

endpackage

// File: rtl/day10_pkg.sv
// Shared day10 types: beat-ordering direction used by the vector readers and writers.
package day10_pkg;

  typedef enum logic {
    DIR__LEFT,
    DIR__RIGHT
  } dir_t;

endpackage

// File: rtl/axi_write_vector_if.sv
// AXI-Stream link carrying vector beats (tdata/tvalid/tready/tlast).
interface axi_stream_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axi_write_vector_beat_select.sv
// vector_beat_select: combinational extractor of beat k of a vector, zero-padded,
// ordered MSB-first (DIR__LEFT) or LSB-first (DIR__RIGHT).
module vector_beat_select
  import day10_pkg::*;
  import axi_write_vector_pkg::*;
#(
  parameter int unsigned MAX_VEC_LENGTH = 8,
  parameter int unsigned AXI_DATA_WIDTH = 8,
  parameter dir_t        DIR            = DIR__LEFT,
  parameter int unsigned LEN_W          = len_w(MAX_VEC_LENGTH),
  parameter int unsigned IDX_W          = beat_w(MAX_VEC_LENGTH, AXI_DATA_WIDTH)
) (
  input  logic [MAX_VEC_LENGTH-1:0] vec_i,
  input  logic [LEN_W-1:0]          len_i,
  input  logic [IDX_W-1:0]          idx_i,
  output logic [AXI_DATA_WIDTH-1:0] beat_o
);

  localparam int unsigned EXT_W = MAX_VEC_LENGTH + AXI_DATA_WIDTH;
  localparam int unsigned SH_W  = $clog2(EXT_W + 1);

  logic [MAX_VEC_LENGTH-1:0] mask_c;
  logic [MAX_VEC_LENGTH-1:0] active_c;
  logic [EXT_W-1:0]          ext_c;
  logic [SH_W-1:0]           len_sh_c;
  logic [SH_W-1:0]           off_c;

  assign len_sh_c = SH_W'(len_i);
  assign off_c    = SH_W'(idx_i) * SH_W'(AXI_DATA_WIDTH);

  // Bits at or above the active length must never reach tdata.
  assign mask_c   = {MAX_VEC_LENGTH{1'b1}} >> (SH_W'(MAX_VEC_LENGTH) - len_sh_c);
  assign active_c = vec_i & mask_c;

  if (DIR == DIR__LEFT) begin : g_left
    // Zero tail below bit 0 supplies the low padding of the final partial beat.
    assign ext_c  = {active_c, {AXI_DATA_WIDTH{1'b0}}};
    assign beat_o = (off_c > len_sh_c) ? '0 : AXI_DATA_WIDTH'(ext_c >> (len_sh_c - off_c));
  end else begin : g_right
    assign ext_c  = {{AXI_DATA_WIDTH{1'b0}}, active_c};
    assign beat_o = AXI_DATA_WIDTH'(ext_c >> off_c);
  end

endmodule

// File: rtl/axi_write_vector.sv
// axi_write_vector: serializes one runtime-length bit vector onto an AXI-Stream master.
// Define AXI_WRITE_VECTOR_ASSERT_EN to compile the protocol assertions.
module axi_write_vector
  import day10_pkg::*;
  import axi_write_vector_pkg::*;
#(
  parameter int unsigned MAX_VEC_LENGTH   = 8,
  parameter int unsigned AXI_DATA_WIDTH   = 8,
  parameter dir_t        WRITE_DIR        = DIR__LEFT,
  parameter int unsigned MAX_VEC_LENGTH_W = len_w(MAX_VEC_LENGTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [MAX_VEC_LENGTH_W-1:0] vec_length,
  input  logic                        vec_last,
  input  logic [MAX_VEC_LENGTH-1:0]   vec,
  output logic                        busy,
  output logic                        ready,
  axi_stream_if.master                data_out
);

  localparam int unsigned BEAT_W = beat_w(MAX_VEC_LENGTH, AXI_DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_e;

  state_e                      state_q, state_d;
  logic [MAX_VEC_LENGTH-1:0]   vec_q, vec_d;
  logic [MAX_VEC_LENGTH_W-1:0] len_q, len_d;
  logic                        last_q, last_d;
  logic [BEAT_W-1:0]           nbeats_q, nbeats_d;
  logic [BEAT_W-1:0]           beat_q, beat_d;
  logic                        tvalid_q, tvalid_d;
  logic                        tlast_q, tlast_d;
  logic [AXI_DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic                        busy_q, busy_d;
  logic                        ready_q, ready_d;

  logic [MAX_VEC_LENGTH_W-1:0] len_clamp_c;
  logic [BEAT_W-1:0]           nbeats_c;
  logic [MAX_VEC_LENGTH-1:0]   sel_vec_c;
  logic [MAX_VEC_LENGTH_W-1:0] sel_len_c;
  logic [BEAT_W-1:0]           sel_idx_c;
  logic [AXI_DATA_WIDTH-1:0]   sel_beat_c;
  logic                        xfer_c;
  logic                        accept_c;

  assign len_clamp_c = (vec_length > MAX_VEC_LENGTH_W'(MAX_VEC_LENGTH))
                     ? MAX_VEC_LENGTH_W'(MAX_VEC_LENGTH) : vec_length;
  // A zero-length vector still occupies one all-zero beat so tlast framing survives.
  assign nbeats_c    = (len_clamp_c == '0) ? BEAT_W'(1)
                     : BEAT_W'((32'(len_clamp_c) + AXI_DATA_WIDTH - 1) / AXI_DATA_WIDTH);
  assign xfer_c      = tvalid_q && data_out.tready;
  assign accept_c    = (state_q == IDLE) && start;

  vector_beat_select #(
    .MAX_VEC_LENGTH (MAX_VEC_LENGTH),
    .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
    .DIR            (WRITE_DIR),
    .LEN_W          (MAX_VEC_LENGTH_W),
    .IDX_W          (BEAT_W)
  ) u_beat_select (
    .vec_i  (sel_vec_c),
    .len_i  (sel_len_c),
    .idx_i  (sel_idx_c),
    .beat_o (sel_beat_c)
  );

  // Next-state logic: the extractor is fed from the inputs in IDLE (beat 0) and
  // from the captured vector otherwise (the beat following the current one).
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    len_d     = len_q;
    last_d    = last_q;
    nbeats_d  = nbeats_q;
    beat_d    = beat_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    tdata_d   = tdata_q;
    busy_d    = busy_q;
    ready_d   = 1'b0;
    sel_vec_c = vec_q;
    sel_len_c = len_q;
    sel_idx_c = beat_q + BEAT_W'(1);

    unique case (state_q)
      IDLE: begin
        sel_vec_c = vec;
        sel_len_c = len_clamp_c;
        sel_idx_c = '0;
        if (start) begin
          state_d  = SEND;
          vec_d    = vec;
          len_d    = len_clamp_c;
          last_d   = vec_last;
          nbeats_d = nbeats_c;
          beat_d   = '0;
          tvalid_d = 1'b1;
          tdata_d  = sel_beat_c;
          tlast_d  = vec_last && (nbeats_c == BEAT_W'(1));
          busy_d   = 1'b1;
        end
      end
      SEND: begin
        if (xfer_c) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == nbeats_q - BEAT_W'(1)) begin
            state_d  = DONE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = '0;
            ready_d  = 1'b1;
          end else begin
            tdata_d = sel_beat_c;
            tlast_d = last_q && (beat_q + BEAT_W'(1) == nbeats_q - BEAT_W'(1));
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      len_q    <= '0;
      last_q   <= 1'b0;
      nbeats_q <= '0;
      beat_q   <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      len_q    <= len_d;
      last_q   <= last_d;
      nbeats_q <= nbeats_d;
      beat_q   <= beat_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign data_out.tvalid = tvalid_q;
  assign data_out.tdata  = tdata_q;
  assign data_out.tlast  = tlast_q;
  assign busy            = busy_q;
  assign ready           = ready_q;

`ifdef AXI_WRITE_VECTOR_ASSERT_EN
  logic [BEAT_W-1:0] xfer_cnt_q;

  // Transfers seen since the current vector was accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_q <= '0;
    end else if (accept_c) begin
      xfer_cnt_q <= '0;
    end else if (xfer_c) begin
      xfer_cnt_q <= xfer_cnt_q + BEAT_W'(1);
    end
  end

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (data_out.tvalid && !data_out.tready) |=>
      (data_out.tvalid && $stable(data_out.tdata) && $stable(data_out.tlast)));

  a_ready_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    ready |=> !ready);

  a_idle_quiet: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == IDLE) |-> !data_out.tvalid);

  a_beat_count: assert property (@(posedge clk) disable iff (!rst_n)
    ready |-> (xfer_cnt_q == nbeats_q));
`endif

endmodule

// File: tb/tb_axi_write_vector.sv
// Self-checking bench: a left- and a right-ordered writer share stimulus and are
// compared beat by beat against a bit-list reference model.
module tb_axi_write_vector;
  import day10_pkg::*;

  localparam int unsigned MAXL = 10;
  localparam int unsigned W    = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [3:0] vec_length = '0;
  logic       vec_last = 1'b0;
  logic [9:0] vec = '0;
  logic       tready = 1'b0;
  logic       busy_l, ready_l, busy_r, ready_r;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_l[$];
  logic [7:0] exp_r[$];
  int         exp_n;
  bit         exp_last;

  axi_stream_if #(.DATA_W(W)) axi_l ();
  axi_stream_if #(.DATA_W(W)) axi_r ();

  assign axi_l.tready = tready;
  assign axi_r.tready = tready;

  axi_write_vector #(.MAX_VEC_LENGTH(MAXL), .AXI_DATA_WIDTH(W), .WRITE_DIR(DIR__LEFT)) dut_l (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_length(vec_length), .vec_last(vec_last),
    .vec(vec), .busy(busy_l), .ready(ready_l), .data_out(axi_l)
  );

  axi_write_vector #(.MAX_VEC_LENGTH(MAXL), .AXI_DATA_WIDTH(W), .WRITE_DIR(DIR__RIGHT)) dut_r (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_length(vec_length), .vec_last(vec_last),
    .vec(vec), .busy(busy_r), .ready(ready_r), .data_out(axi_r)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: list the active bits in stream order, then cut into W-bit beats.
  task automatic build_exp(input logic [9:0] v, input int len_in, input bit last);
    int len;
    logic [31:0] v32;
    len = (len_in > int'(MAXL)) ? int'(MAXL) : len_in;
    v32 = 32'(v);
    exp_n = (len == 0) ? 1 : (len + int'(W) - 1) / int'(W);
    exp_last = last;
    exp_l.delete();
    exp_r.delete();
    for (int k = 0; k < exp_n; k++) begin
      logic [7:0] bl;
      logic [7:0] br;
      bl = '0;
      br = '0;
      for (int j = 0; j < int'(W); j++) begin
        int i;
        i = k * int'(W) + j;
        if (i < len) begin
          bl[3'(7 - j)] = v32[5'(len - 1 - i)];
          br[3'(j)]     = v32[5'(i)];
        end
      end
      exp_l.push_back(bl);
      exp_r.push_back(br);
    end
  endtask

  // mode 0: tready=1; 1: tready low for 3 cycles per beat; 2: random tready.
  task automatic run_vec(input logic [9:0] v, input int len, input bit last,
                         input int mode, input bit poke);
    int k;
    int cyc;
    int stall_cnt;
    bit stalled;
    logic [7:0] hold_l, hold_r;
    k = 0;
    cyc = 0;
    stall_cnt = 0;
    stalled = 0;
    hold_l = '0;
    hold_r = '0;
    build_exp(v, len, last);
    @(negedge clk);
    vec = v;
    vec_length = 4'(len);
    vec_last = last;
    start = 1'b1;
    @(negedge clk);
    start = poke;
    vec = 10'($urandom);
    vec_length = 4'($urandom);
    vec_last = ~last;
    check("busy_after_start", 32'(busy_l), 32'(1));
    check("tvalid_first_beat", 32'(axi_r.tvalid), 32'(1));
    while (k < exp_n && cyc < 200) begin
      if (stalled) begin
        check("hold_tvalid", 32'(axi_l.tvalid), 32'(1));
        check("hold_tdata_l", 32'(axi_l.tdata), 32'(hold_l));
        check("hold_tdata_r", 32'(axi_r.tdata), 32'(hold_r));
      end
      case (mode)
        0:       tready = 1'b1;
        1:       tready = (stall_cnt == 3);
        default: tready = 1'($urandom_range(0, 1));
      endcase
      check("ready_early", 32'({ready_l, ready_r}), 32'(0));
      if (axi_l.tvalid && tready) begin
        check("tdata_left", 32'(axi_l.tdata), 32'(exp_l[k]));
        check("tdata_right", 32'(axi_r.tdata), 32'(exp_r[k]));
        check("tlast_left", 32'(axi_l.tlast), 32'(exp_last && (k == exp_n - 1)));
        check("tlast_right", 32'(axi_r.tlast), 32'(exp_last && (k == exp_n - 1)));
        k++;
        stall_cnt = 0;
        stalled = 0;
      end else begin
        stalled = axi_l.tvalid;
        hold_l = axi_l.tdata;
        hold_r = axi_r.tdata;
        stall_cnt++;
      end
      cyc++;
      @(negedge clk);
      if (poke) begin
        vec = 10'($urandom);
        vec_length = 4'($urandom);
      end
    end
    check("beat_count", 32'(k), 32'(exp_n));
    check("ready_pulse", 32'({ready_l, ready_r}), 32'(3));
    check("tvalid_done", 32'({axi_l.tvalid, axi_r.tvalid}), 32'(0));
    @(negedge clk);
    start = 1'b0;
    check("ready_once", 32'({ready_l, ready_r}), 32'(0));
    check("busy_cleared", 32'({busy_l, busy_r}), 32'(0));
    check("no_extra_beat", 32'({axi_l.tvalid, axi_r.tvalid}), 32'(0));
    if (poke) begin
      @(negedge clk);
      check("no_extra_beat_late", 32'({axi_l.tvalid, axi_r.tvalid}), 32'(0));
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_tvalid", 32'({axi_l.tvalid, axi_r.tvalid}), 32'(0));
    check("rst_tlast", 32'({axi_l.tlast, axi_r.tlast}), 32'(0));
    check("rst_tdata", 32'({axi_l.tdata, axi_r.tdata}), 32'(0));
    check("rst_busy", 32'({busy_l, busy_r}), 32'(0));
    check("rst_ready", 32'({ready_l, ready_r}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_vec(10'b1011001110, 10, 1'b1, 0, 1'b0);
    run_vec(10'b1111101110, 5, 1'b0, 0, 1'b0);
    run_vec(10'b1011001110, 10, 1'b1, 1, 1'b0);
    run_vec(10'b1111111111, 0, 1'b1, 0, 1'b1);
    run_vec(10'b0110100101, 15, 1'b1, 2, 1'b0);

    // Reset while the second beat is stalled.
    build_exp(10'b1011001110, 10, 1'b1);
    @(negedge clk);
    vec = 10'b1011001110;
    vec_length = 4'd10;
    vec_last = 1'b1;
    start = 1'b1;
    tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    tready = 1'b0;
    check("second_beat_l", 32'(axi_l.tdata), 32'(exp_l[1]));
    check("second_beat_r", 32'(axi_r.tdata), 32'(exp_r[1]));
    #2 rst_n = 1'b0;
    #1;
    check("async_drop_tvalid", 32'({axi_l.tvalid, axi_r.tvalid}), 32'(0));
    check("async_no_ready", 32'({ready_l, ready_r}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'({ready_l, ready_r}), 32'(0));
    check("post_rst_busy", 32'({busy_l, busy_r}), 32'(0));
    run_vec(10'b1011001110, 10, 1'b1, 0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      run_vec(10'($urandom), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
